hasti_slave_arbiter: RTL and testbench

// - Arbitration controller for one shared HASTI slave port reached by two master paths (upstream bus decoders).
// - Chooses the address-phase owner and tracks the data-phase owner.
// - Strobes capture of a losing master's address phase and stalls that master via its hready until it is served.
// - Drives the select/stall controls of the slave-side mux; address/data muxing itself stays in the mux.

---
 rtl/hasti_arb_pkg.sv | 33 +++
 rtl/hasti_slave_arbiter_pick.sv | 21 ++
 rtl/hasti_slave_arbiter.sv | 117 +++++++++++
 tb/tb_hasti_slave_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hasti_arb_pkg.sv
// Shared types and constants for the two-path HASTI slave-port arbiter.
package hasti_arb_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN0     = 2'd1,
        OWN1     = 2'd2
    } owner_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int HOLD_W = 4;

    function automatic logic [1:0] owner_onehot(input owner_t o);
        case (o)
            OWN0:    return 2'b01;
            OWN1:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic owner_t onehot_owner(input logic [1:0] oh);
        case (oh)
            2'b01:   return OWN0;
            2'b10:   return OWN1;
            default: return OWN_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/hasti_slave_arbiter_pick.sv
// Combinational winner selection: pending requests beat live ones, ties go to ptr_i.
module hasti_arb_pick
    import hasti_arb_pkg::*;
(
    input  logic [1:0] pend_i,
    input  logic [1:0] live_i,
    input  logic       ptr_i,
    output logic [1:0] win_o
);

    logic [1:0] cand;

    always_comb begin
        cand  = (|pend_i) ? pend_i : live_i;
        win_o = cand;
        if (&cand) begin
            win_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/hasti_slave_arbiter.sv
// Arbitration control for one HASTI slave port shared by two master paths.
// Define HASTI_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority to path 0.
module hasti_slave_arbiter
    import hasti_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       hclk,
    input  logic       hresetn,
    input  logic [1:0] m_htrans0,
    input  logic [1:0] m_htrans1,
    input  logic [1:0] m_hmastlock,
    input  logic       s_hreadyout,
    output logic [1:0] a_grant,
    output logic       a_use_pend,
    output logic [1:0] cap,
    output logic [1:0] d_grant,
    output logic       s_htrans_en,
    output logic [1:0] m_hready
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    owner_t            state_q, state_d;
    logic [1:0]        pend_q, pend_d;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_base;
    logic [1:0]        live, seq, nonseq, req, own_oh, keep, pick_win, win;
    logic              hold_lt, ptr;

`ifdef HASTI_ARB_ROUND_ROBIN_EN
    logic rr_q, rr_d;
    assign ptr = rr_q;
`else
    assign ptr = 1'b0;
`endif

    assign live    = {m_htrans1[1], m_htrans0[1]};
    assign seq     = {m_htrans1 == HTRANS_SEQ, m_htrans0 == HTRANS_SEQ};
    assign nonseq  = {m_htrans1 == HTRANS_NONSEQ, m_htrans0 == HTRANS_NONSEQ};
    assign req     = pend_q | live;
    assign own_oh  = owner_onehot(state_q);
    assign hold_lt = hold_q < HOLD_MAX;

    // Owner keeps the port while locked, mid-burst, or within its hold budget under contention.
    assign keep[0] = own_oh[0] & (m_hmastlock[0] | seq[0] | (&req & hold_lt));
    assign keep[1] = own_oh[1] & (m_hmastlock[1] | seq[1] | (&req & hold_lt));

    hasti_arb_pick u_pick (
        .pend_i (pend_q),
        .live_i (live),
        .ptr_i  (ptr),
        .win_o  (pick_win)
    );

    always_comb begin
        if (!hresetn) begin
            win = 2'b00;
        end else if (!s_hreadyout) begin
            win = own_oh;
        end else if (|keep) begin
            win = keep;
        end else begin
            win = pick_win;
        end
    end

    assign d_grant     = own_oh;
    assign m_hready    = ~pend_q & (~own_oh | {2{s_hreadyout}});
    assign a_grant     = win;
    assign a_use_pend  = |(win & pend_q);
    assign s_htrans_en = |win;
    // A path whose address phase the master believes accepted, but which did not win, is captured.
    assign cap         = live & m_hready & ~pend_q & ~win & {2{hresetn}};

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q | cap;
        hold_d    = hold_q;
        hold_base = (win == own_oh) ? hold_q : '0;
`ifdef HASTI_ARB_ROUND_ROBIN_EN
        rr_d      = rr_q;
`endif
        if (s_hreadyout) begin
            state_d = onehot_owner(win);
            pend_d  = (pend_q & ~win) | cap;
            hold_d  = hold_base;
            // Captured transfers always began as NONSEQ, so they count toward the hold budget.
            if ((|(win & (pend_q | nonseq))) && (hold_base < HOLD_MAX)) begin
                hold_d = hold_base + HOLD_W'(1);
            end
`ifdef HASTI_ARB_ROUND_ROBIN_EN
            if ((|win) && (win != own_oh)) begin
                rr_d = win[0];
            end
`endif
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= OWN_IDLE;
            pend_q  <= 2'b00;
            hold_q  <= '0;
`ifdef HASTI_ARB_ROUND_ROBIN_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            hold_q  <= hold_d;
`ifdef HASTI_ARB_ROUND_ROBIN_EN
            rr_q    <= rr_d;
`endif
        end
    end

endmodule

// File: tb/tb_hasti_slave_arbiter.sv
// Bench for hasti_slave_arbiter: directed scenarios plus random traffic against a behavioural model.
`timescale 1ns/1ps
module tb_hasti_slave_arbiter;

    localparam int MAX_HOLD = 4;
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    logic       hclk = 1'b0;
    logic       hresetn = 1'b1;
    logic [1:0] m_htrans0 = 2'b00;
    logic [1:0] m_htrans1 = 2'b00;
    logic [1:0] m_hmastlock = 2'b00;
    logic       s_hreadyout = 1'b1;
    logic [1:0] a_grant, cap, d_grant, m_hready;
    logic       a_use_pend, s_htrans_en;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: owner -1 means no owner.
    int       m_owner;
    bit [1:0] m_pend;
    int       m_hold;
    int       m_rr;
    int       last_w;
    bit [1:0] last_cap;

    always #5 hclk = ~hclk;

    hasti_slave_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .m_htrans0   (m_htrans0),
        .m_htrans1   (m_htrans1),
        .m_hmastlock (m_hmastlock),
        .s_hreadyout (s_hreadyout),
        .a_grant     (a_grant),
        .a_use_pend  (a_use_pend),
        .cap         (cap),
        .d_grant     (d_grant),
        .s_htrans_en (s_htrans_en),
        .m_hready    (m_hready)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] tr(input int p);
        return (p == 1) ? m_htrans1 : m_htrans0;
    endfunction

    function automatic bit wants(input int p);
        return m_pend[p] || (tr(p) >= 2'd2);
    endfunction

    // Scan pending requesters first, then live ones, starting from the tie-break favourite.
    function automatic int choose();
        int first;
        first = 0;
`ifdef HASTI_ARB_ROUND_ROBIN_EN
        first = m_rr;
`endif
        for (int k = 0; k < 2; k++) begin
            if (m_pend[(first + k) % 2]) return (first + k) % 2;
        end
        for (int k = 0; k < 2; k++) begin
            if (tr((first + k) % 2) >= 2'd2) return (first + k) % 2;
        end
        return -1;
    endfunction

    function automatic int winner();
        int o;
        if (!hresetn) return -1;
        if (!s_hreadyout) return m_owner;
        if (m_owner >= 0) begin
            o = m_owner;
            if (m_hmastlock[o] || (tr(o) == HT_SEQ) || (wants(0) && wants(1) && (m_hold < MAX_HOLD)))
                return o;
        end
        return choose();
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_pend  = 2'b00;
        m_hold  = 0;
        m_rr    = 0;
    endtask

    task automatic compare_outputs();
        int w;
        logic [1:0] eg, ec, ed, eh;
        logic eu;
        w  = winner();
        ed = (m_owner < 0) ? 2'b00 : 2'(1 << m_owner);
        eg = (w < 0) ? 2'b00 : 2'(1 << w);
        for (int p = 0; p < 2; p++) begin
            eh[p] = m_pend[p] ? 1'b0 : ((m_owner == p) ? s_hreadyout : 1'b1);
            ec[p] = hresetn && (tr(p) >= 2'd2) && eh[p] && !m_pend[p] && (w != p);
        end
        eu = (w >= 0) ? m_pend[w] : 1'b0;
        check("a_grant", 8'(a_grant), 8'(eg));
        check("d_grant", 8'(d_grant), 8'(ed));
        check("cap", 8'(cap), 8'(ec));
        check("m_hready", 8'(m_hready), 8'(eh));
        check("a_use_pend", 8'(a_use_pend), 8'(eu));
        check("s_htrans_en", 8'(s_htrans_en), 8'(eg != 2'b00));
        last_w   = w;
        last_cap = ec;
    endtask

    task automatic model_edge();
        bit nonseq_acc;
        int w;
        w = last_w;
        if (s_hreadyout) begin
            if (w >= 0) begin
                nonseq_acc = m_pend[w] || (tr(w) == HT_NONSEQ);
                if (w != m_owner) begin
                    m_hold = 0;
                    m_rr   = 1 - w;
                end
                if (nonseq_acc && (m_hold < MAX_HOLD)) m_hold++;
                m_pend[w] = 1'b0;
            end else begin
                m_hold = 0;
            end
            m_owner = w;
        end
        m_pend = m_pend | last_cap;
    endtask

    task automatic drive(input logic [1:0] t0, input logic [1:0] t1, input logic [1:0] lk,
                         input logic rdy);
        m_htrans0   = t0;
        m_htrans1   = t1;
        m_hmastlock = lk;
        s_hreadyout = rdy;
    endtask

    // Drive, then compare at the falling edge; caller may add checks before advance().
    task automatic cyc(input logic [1:0] t0, input logic [1:0] t1, input logic [1:0] lk,
                       input logic rdy);
        drive(t0, t1, lk, rdy);
        @(negedge hclk);
        compare_outputs();
    endtask

    task automatic advance();
        @(posedge hclk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        hresetn = 1'b0;
        #1;
        model_reset();
        check("rst_a_grant", 8'(a_grant), 8'h00);
        check("rst_d_grant", 8'(d_grant), 8'h00);
        check("rst_cap", 8'(cap), 8'h00);
        check("rst_a_use_pend", 8'(a_use_pend), 8'h00);
        check("rst_s_htrans_en", 8'(s_htrans_en), 8'h00);
        check("rst_m_hready", 8'(m_hready), 8'h03);
        @(posedge hclk);
        #1;
        drive(HT_IDLE, HT_IDLE, 2'b00, 1'b1);
        @(negedge hclk);
        hresetn = 1'b1;
        #1;
        compare_outputs();
        advance();
    endtask

    function automatic logic [1:0] rand_trans();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 3) return HT_IDLE;
        if (r < 4) return 2'b01;
        if (r < 8) return HT_NONSEQ;
        return HT_SEQ;
    endfunction

    initial begin
        logic [1:0] t0, t1, lk;
        logic rdy;
        #2;
        apply_reset();

        // Path 0 alone: same-cycle grant, data phase follows slave ready.
        cyc(HT_NONSEQ, HT_IDLE, 2'b00, 1'b1);
        check("s1_a_grant", 8'(a_grant), 8'h01);
        check("s1_cap", 8'(cap), 8'h00);
        advance();
        cyc(HT_IDLE, HT_IDLE, 2'b00, 1'b0);
        check("s1_d_grant", 8'(d_grant), 8'h01);
        check("s1_hready_wait", 8'(m_hready), 8'h02);
        advance();
        cyc(HT_IDLE, HT_IDLE, 2'b00, 1'b1);
        check("s1_hready_done", 8'(m_hready), 8'h03);
        advance();

        // Simultaneous NONSEQ from IDLE.
        apply_reset();
        cyc(HT_NONSEQ, HT_NONSEQ, 2'b00, 1'b1);
        check("s2_a_grant", 8'(a_grant), 8'h01);
        check("s2_cap", 8'(cap), 8'h02);
        advance();
        cyc(HT_IDLE, HT_NONSEQ, 2'b00, 1'b1);
        check("s2_hready", 8'(m_hready), 8'h01);
        check("s2_a_grant_pend", 8'(a_grant), 8'h02);
        check("s2_use_pend", 8'(a_use_pend), 8'h01);
        advance();
        cyc(HT_IDLE, HT_IDLE, 2'b00, 1'b1);
        check("s2_d_grant", 8'(d_grant), 8'h02);
        advance();

        // Locked 8-beat burst on path 0 while path 1 waits.
        apply_reset();
        cyc(HT_NONSEQ, HT_IDLE, 2'b01, 1'b1);
        check("s3_beat1", 8'(a_grant), 8'h01);
        advance();
        for (int b = 2; b <= 8; b++) begin
            cyc(HT_SEQ, HT_NONSEQ, 2'b01, 1'b1);
            check("s3_locked_beat", 8'(a_grant), 8'h01);
            advance();
        end
        cyc(HT_IDLE, HT_NONSEQ, 2'b00, 1'b1);
        check("s3_after_lock", 8'(a_grant), 8'h02);
        check("s3_use_pend", 8'(a_use_pend), 8'h01);
        advance();

        // Back-to-back NONSEQs on path 0 hit the hold limit.
        apply_reset();
        cyc(HT_NONSEQ, HT_IDLE, 2'b00, 1'b1);
        check("s4_ns1", 8'(a_grant), 8'h01);
        advance();
        for (int n = 2; n <= 4; n++) begin
            cyc(HT_NONSEQ, HT_NONSEQ, 2'b00, 1'b1);
            check("s4_ns_hold", 8'(a_grant), 8'h01);
            advance();
        end
        cyc(HT_NONSEQ, HT_NONSEQ, 2'b00, 1'b1);
        check("s4_forced_switch", 8'(a_grant), 8'h02);
        advance();
        for (int n = 0; n < 3; n++) begin
            cyc(HT_IDLE, HT_IDLE, 2'b00, 1'b1);
            advance();
        end

        // Slave stall during a contended transfer.
        apply_reset();
        cyc(HT_NONSEQ, HT_NONSEQ, 2'b00, 1'b1);
        advance();
        for (int n = 0; n < 3; n++) begin
            cyc(HT_IDLE, HT_NONSEQ, 2'b00, 1'b0);
            check("s5_a_grant_hold", 8'(a_grant), 8'h01);
            check("s5_d_grant_hold", 8'(d_grant), 8'h01);
            check("s5_hready_hold", 8'(m_hready), 8'h00);
            advance();
        end
        cyc(HT_IDLE, HT_NONSEQ, 2'b00, 1'b1);
        check("s5_release", 8'(a_grant), 8'h02);
        check("s5_use_pend", 8'(a_use_pend), 8'h01);
        advance();

        // Reset while a captured transfer is outstanding.
        apply_reset();
        cyc(HT_NONSEQ, HT_NONSEQ, 2'b00, 1'b1);
        advance();
        drive(HT_IDLE, HT_NONSEQ, 2'b00, 1'b1);
        apply_reset();
        cyc(HT_IDLE, HT_IDLE, 2'b00, 1'b1);
        check("s6_no_stale_pend", 8'(m_hready), 8'h03);
        check("s6_a_grant", 8'(a_grant), 8'h00);
        advance();

        // Random traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                apply_reset();
            end else begin
                t0    = rand_trans();
                t1    = rand_trans();
                lk[0] = ($urandom_range(0, 9) == 0);
                lk[1] = ($urandom_range(0, 9) == 0);
                rdy   = ($urandom_range(0, 3) != 0);
                cyc(t0, t1, lk, rdy);
                advance();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
